// File: rtl/instr_fetch_queue.sv
// Dual-issue instruction fetch queue: fetches up to two ROM words per en tick into a
// circular buffer and presents the two oldest entries to the scheduler.
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROM_WORDS = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] imem_addr0,
  output logic [ADDR_W-1:0] imem_addr1,
  input  logic [31:0]       imem_data0,
  input  logic [31:0]       imem_data1,
  input  logic              pop0,
  input  logic              pop1,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [31:0]       instruction0,
  output logic [31:0]       instruction1,
  output logic              valid0,
  output logic              valid1,
  output logic              nothing_filled,
  output logic              done
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned PcW  = ADDR_W + 1;

  localparam logic [CntW-1:0] CntDepth = CntW'(DEPTH);
  localparam logic [PcW-1:0]  PcEnd    = PcW'(ROM_WORDS);
  localparam logic [31:0]     Nop      = 32'h0000_0013;

  logic [31:0]     storage_q [DEPTH];
  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PcW-1:0]  pc_q, pc_d;

  logic [1:0]      npop;
  logic [1:0]      npush;
  logic [CntW-1:0] free_slots;
  logic [PcW-1:0]  rom_left;
  logic [PcW-1:0]  redirect_pc;
  logic [IdxW-1:0] head_nxt;
  logic [IdxW-1:0] tail_nxt;
  logic            wr0;
  logic            wr1;

  assign head_nxt    = head_q + IdxW'(1);
  assign tail_nxt    = tail_q + IdxW'(1);
  assign redirect_pc = {1'b0, redirect_addr};

  // Pops are clamped to what is actually held; pop1 without pop0 is ignored.
  always_comb begin
    npop = 2'd0;
    if (pop0 && pop1 && (count_q >= CntW'(2))) begin
      npop = 2'd2;
    end else if (pop0 && (count_q != '0)) begin
      npop = 2'd1;
    end
  end

  // Slots freed by this tick's pops are reusable by this tick's pushes.
  assign free_slots = CntDepth - (count_q - CntW'(npop));
  assign rom_left   = PcEnd - pc_q;

  always_comb begin
    npush = 2'd0;
    if ((free_slots >= CntW'(2)) && (rom_left >= PcW'(2))) begin
      npush = 2'd2;
    end else if ((free_slots != '0) && (rom_left != '0)) begin
      npush = 2'd1;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    wr0     = 1'b0;
    wr1     = 1'b0;
    if (en) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        // Out-of-range redirects park fetch at the end of the program.
        pc_d    = (redirect_pc >= PcEnd) ? PcEnd : redirect_pc;
      end else begin
        head_d  = head_q + IdxW'(npop);
        tail_d  = tail_q + IdxW'(npush);
        count_d = count_q + CntW'(npush) - CntW'(npop);
        pc_d    = pc_q + PcW'(npush);
        wr0     = (npush != 2'd0);
        wr1     = (npush == 2'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

  // Entry contents need no reset: outputs are masked to NOP until valid.
  always_ff @(posedge clk) begin
    if (!rst && wr0) begin
      storage_q[tail_q] <= imem_data0;
    end
    if (!rst && wr1) begin
      storage_q[tail_nxt] <= imem_data1;
    end
  end

  always_comb begin
    valid0         = (count_q != '0);
    valid1         = (count_q >= CntW'(2));
    nothing_filled = (count_q == '0);
    done           = (pc_q == PcEnd) && (count_q == '0);
    instruction0   = valid0 ? storage_q[head_q] : Nop;
    instruction1   = valid1 ? storage_q[head_nxt] : Nop;
    imem_addr0     = pc_q[ADDR_W-1:0];
    imem_addr1     = pc_q[ADDR_W-1:0] + ADDR_W'(1);
  end

  assert property (@(posedge clk) disable iff (rst) count_q <= CntDepth);
  assert property (@(posedge clk) disable iff (rst) pc_q <= PcEnd);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: two instances (64-word and 5-word programs)
// driven with directed ticks; a negedge monitor checks queued expectations.
module tb_instr_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en_a = 1'b0, pop0_a = 1'b0, pop1_a = 1'b0, flush_a = 1'b0;
  logic [5:0]  ra_a = '0;
  logic [5:0]  a0_a, a1_a;
  logic [31:0] d0_a, d1_a, i0_a, i1_a;
  logic        v0_a, v1_a, nf_a, dn_a;

  logic        en_b = 1'b0, pop0_b = 1'b0, pop1_b = 1'b0, flush_b = 1'b0;
  logic [5:0]  ra_b = '0;
  logic [5:0]  a0_b, a1_b;
  logic [31:0] d0_b, d1_b, i0_b, i1_b;
  logic        v0_b, v1_b, nf_b, dn_b;

  // ROM word at address i is 0x100 + i.
  assign d0_a = 32'h100 + {26'd0, a0_a};
  assign d1_a = 32'h100 + {26'd0, a1_a};
  assign d0_b = 32'h100 + {26'd0, a0_b};
  assign d1_b = 32'h100 + {26'd0, a1_b};

  instr_fetch_queue #(.DEPTH(8), .ROM_WORDS(64), .ADDR_W(6)) dut_a (
    .clk(clk), .rst(rst), .en(en_a),
    .imem_addr0(a0_a), .imem_addr1(a1_a), .imem_data0(d0_a), .imem_data1(d1_a),
    .pop0(pop0_a), .pop1(pop1_a), .flush(flush_a), .redirect_addr(ra_a),
    .instruction0(i0_a), .instruction1(i1_a), .valid0(v0_a), .valid1(v1_a),
    .nothing_filled(nf_a), .done(dn_a)
  );

  instr_fetch_queue #(.DEPTH(8), .ROM_WORDS(5), .ADDR_W(6)) dut_b (
    .clk(clk), .rst(rst), .en(en_b),
    .imem_addr0(a0_b), .imem_addr1(a1_b), .imem_data0(d0_b), .imem_data1(d1_b),
    .pop0(pop0_b), .pop1(pop1_b), .flush(flush_b), .redirect_addr(ra_b),
    .instruction0(i0_b), .instruction1(i1_b), .valid0(v0_b), .valid1(v1_b),
    .nothing_filled(nf_b), .done(dn_b)
  );

  typedef struct {
    int          cyc;
    bit          sel;
    string       nm;
    logic        v0, v1, nf, dn;
    logic [31:0] i0, i1;
    logic [5:0]  a0, a1;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk(e.nm, "cycle", 32'(cyc), 32'(e.cyc));
        if (!e.sel) begin
          chk(e.nm, "valid0", 32'(v0_a), 32'(e.v0));
          chk(e.nm, "valid1", 32'(v1_a), 32'(e.v1));
          chk(e.nm, "instruction0", i0_a, e.i0);
          chk(e.nm, "instruction1", i1_a, e.i1);
          chk(e.nm, "nothing_filled", 32'(nf_a), 32'(e.nf));
          chk(e.nm, "done", 32'(dn_a), 32'(e.dn));
          chk(e.nm, "imem_addr0", 32'(a0_a), 32'(e.a0));
          chk(e.nm, "imem_addr1", 32'(a1_a), 32'(e.a1));
        end else begin
          chk(e.nm, "valid0", 32'(v0_b), 32'(e.v0));
          chk(e.nm, "valid1", 32'(v1_b), 32'(e.v1));
          chk(e.nm, "instruction0", i0_b, e.i0);
          chk(e.nm, "instruction1", i1_b, e.i1);
          chk(e.nm, "nothing_filled", 32'(nf_b), 32'(e.nf));
          chk(e.nm, "done", 32'(dn_b), 32'(e.dn));
          chk(e.nm, "imem_addr0", 32'(a0_b), 32'(e.a0));
          chk(e.nm, "imem_addr1", 32'(a1_b), 32'(e.a1));
        end
      end
    end
  end

  task automatic expect_out(input bit sel, input string nm, input logic v0, input logic v1,
                            input logic [31:0] i0, input logic [31:0] i1, input logic nf,
                            input logic dn, input logic [5:0] a0);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.nm  = nm;
    e.v0  = v0;
    e.v1  = v1;
    e.i0  = i0;
    e.i1  = i1;
    e.nf  = nf;
    e.dn  = dn;
    e.a0  = a0;
    e.a1  = a0 + 6'd1;
    sb.push_back(e);
  endtask

  task automatic clear_inputs();
    en_a = 1'b0; pop0_a = 1'b0; pop1_a = 1'b0; flush_a = 1'b0; ra_a = '0;
    en_b = 1'b0; pop0_b = 1'b0; pop1_b = 1'b0; flush_b = 1'b0; ra_b = '0;
  endtask

  task automatic step(input bit sel, input bit e, input bit p0, input bit p1, input bit fl,
                      input logic [5:0] ra);
    if (!sel) begin
      en_a = e; pop0_a = p0; pop1_a = p1; flush_a = fl; ra_a = ra;
    end else begin
      en_b = e; pop0_b = p0; pop1_b = p1; flush_b = fl; ra_b = ra;
    end
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    // Reset with en, pops and flush all active: reset must win.
    rst = 1'b1; en_a = 1'b1; pop0_a = 1'b1; pop1_a = 1'b1; flush_a = 1'b1; ra_a = 6'd9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    expect_out(0, "a_reset", 0, 0, NOP, NOP, 1, 0, 6'd0);

    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_fill1", 1, 1, 32'h100, 32'h101, 0, 0, 6'd2);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_fill2", 1, 1, 32'h100, 32'h101, 0, 0, 6'd4);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_fill3", 1, 1, 32'h100, 32'h101, 0, 0, 6'd6);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_fill4", 1, 1, 32'h100, 32'h101, 0, 0, 6'd8);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_full", 1, 1, 32'h100, 32'h101, 0, 0, 6'd8);
    step(0, 0, 1, 1, 1, 6'd5);
    expect_out(0, "a_en_low", 1, 1, 32'h100, 32'h101, 0, 0, 6'd8);

    // Full queue, dual pop each tick: retire 2 and refill 2, head wraps past 7.
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 1, 1, 0, 0);
      expect_out(0, $sformatf("a_pop2_%0d", k), 1, 1, 32'h100 + 32'(2 * k),
                 32'h101 + 32'(2 * k), 0, 0, 6'(8 + 2 * k));
    end

    step(0, 1, 0, 1, 0, 0); expect_out(0, "a_pop1_only", 1, 1, 32'h10c, 32'h10d, 0, 0, 6'd20);
    step(0, 1, 1, 1, 1, 6'd3); expect_out(0, "a_flush3", 0, 0, NOP, NOP, 1, 0, 6'd3);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_refetch", 1, 1, 32'h103, 32'h104, 0, 0, 6'd5);
    step(0, 1, 1, 0, 0, 0); expect_out(0, "a_pop0", 1, 1, 32'h104, 32'h105, 0, 0, 6'd7);
    step(0, 1, 0, 0, 1, 6'd63); expect_out(0, "a_flush63", 0, 0, NOP, NOP, 1, 0, 6'd63);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_push1", 1, 0, 32'h13f, NOP, 0, 0, 6'd0);
    step(0, 1, 0, 1, 0, 0); expect_out(0, "a_pop1_alone", 1, 0, 32'h13f, NOP, 0, 0, 6'd0);
    step(0, 1, 1, 1, 0, 0); expect_out(0, "a_overpop", 0, 0, NOP, NOP, 1, 1, 6'd0);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_stopped", 0, 0, NOP, NOP, 1, 1, 6'd0);
    step(0, 1, 0, 0, 1, 6'd0); expect_out(0, "a_flush0", 0, 0, NOP, NOP, 1, 0, 6'd0);

    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_build1", 1, 1, 32'h100, 32'h101, 0, 0, 6'd2);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_build2", 1, 1, 32'h100, 32'h101, 0, 0, 6'd4);
    step(0, 1, 1, 0, 0, 0); expect_out(0, "a_build5", 1, 1, 32'h101, 32'h102, 0, 0, 6'd6);

    // Mid-run reset with en low and competing controls raised.
    rst = 1'b1; pop0_a = 1'b1; pop1_a = 1'b1; flush_a = 1'b1; ra_a = 6'd9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    expect_out(0, "a_mid_reset", 0, 0, NOP, NOP, 1, 0, 6'd0);
    step(0, 1, 0, 0, 0, 0); expect_out(0, "a_post_reset", 1, 1, 32'h100, 32'h101, 0, 0, 6'd2);

    // Five-word program: pushes 2, 2, 1 then stops at pc 5.
    expect_out(1, "b_reset", 0, 0, NOP, NOP, 1, 0, 6'd0);
    step(1, 1, 0, 0, 0, 0); expect_out(1, "b_fill1", 1, 1, 32'h100, 32'h101, 0, 0, 6'd2);
    step(1, 1, 0, 0, 0, 0); expect_out(1, "b_fill2", 1, 1, 32'h100, 32'h101, 0, 0, 6'd4);
    step(1, 1, 0, 0, 0, 0); expect_out(1, "b_fill3", 1, 1, 32'h100, 32'h101, 0, 0, 6'd5);
    step(1, 1, 0, 0, 0, 0); expect_out(1, "b_hold", 1, 1, 32'h100, 32'h101, 0, 0, 6'd5);
    step(1, 1, 1, 1, 0, 0); expect_out(1, "b_pop_a", 1, 1, 32'h102, 32'h103, 0, 0, 6'd5);
    step(1, 1, 1, 1, 0, 0); expect_out(1, "b_pop_b", 1, 0, 32'h104, NOP, 0, 0, 6'd5);
    step(1, 1, 1, 1, 0, 0); expect_out(1, "b_drained", 0, 0, NOP, NOP, 1, 1, 6'd5);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
